// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
// The master drives operands and start; the slave returns the result and status.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             busy;
  logic             done;

  modport master (output start, A, B, Bin, input D, Bout, busy, done);
  modport slave  (input start, A, B, Bin, output D, Bout, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first, one bit per clock.
// A single borrow flop ripples across cycles; D/Bout update only when the last bit lands.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             dbit;
  logic [WIDTH:0]   res_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    dbit    = 1'b0;
    res_ext = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          brw_d   = bus.Bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        dbit    = a_q[0] ^ b_q[0] ^ brw_q;
        brw_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // Extended vector keeps the shift legal for WIDTH=1.
        res_ext = {dbit, res_q};
        res_d   = res_ext[WIDTH:1];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          d_d     = res_ext[WIDTH:1];
          bout_d  = brw_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
endmodule
